instruction_fetch_unit: RTL

- Initiator side of the instruction memory read port.
- Owns the PC and issues word-addressed read requests to the instruction memory (fixed response latency), then buffers the returned instructions in a small queue.
- Delivers each instruction together with its PC to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes all wrong-path state.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 51 +++++
 rtl/instruction_fetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding, widths and queue entry layout.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with push/pop/flush, occupancy count and registered storage head.
// Also intended for the data-side load buffer, so it carries no fetch-specific knowledge.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count < CW'(DEPTH)) | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and imem read initiator; credit-limited issue, fixed-latency response pipe, decode queue.
// Optional FETCH_STALL_COUNT_EN adds a saturating stall_cycles counter of credit-starved RUN cycles.
//   state | meaning
//   IDLE  | no fetching, waiting for fetch_enable
//   RUN   | issuing requests while credit allows
//   DRAIN | no new requests, waiting for in-flight responses
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter int          IMEM_LATENCY = 2,
    parameter int          QUEUE_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_address,
    output logic        imem_read_enable,
    input  logic [31:0] imem_data_in,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        fetch_busy
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    fetch_state_e                    state;
    fetch_state_e                    next_state;
    logic [ADDR_W-1:0]               pc;
    logic [IMEM_LATENCY-1:0]         pipe_valid;
    logic [ADDR_W-1:0]               pipe_pc [IMEM_LATENCY];
    logic [$clog2(QUEUE_DEPTH):0]    q_count;
    fetch_entry_t                    q_head;
    fetch_entry_t                    q_push_data;
    logic                            q_push;
    logic                            pop;
    logic                            credit_ok;
    logic                            issue;

    assign pop         = instr_valid & instr_ready;
    assign q_push      = pipe_valid[IMEM_LATENCY-1] & ~redirect_valid;
    assign q_push_data = '{pc: pipe_pc[IMEM_LATENCY-1], instr: imem_data_in};

    // Credit covers the queue, the response pipe and the request on the bus now;
    // a pop this cycle frees one slot, which keeps the stream at one word per cycle.
    assign credit_ok = (int'(q_count) + $countones(pipe_valid) + int'(imem_read_enable)
                        - int'(pop)) < QUEUE_DEPTH;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = fetch_enable ? RUN : IDLE;
            RUN:     next_state = fetch_enable ? RUN : DRAIN;
            DRAIN:   next_state = fetch_enable ? RUN : ((pipe_valid == '0) ? IDLE : DRAIN);
            default: next_state = IDLE;
        endcase
    end

    // Issue is decided for the state being entered, so the strobe is only ever high in RUN.
    assign issue = (next_state == RUN) & ~redirect_valid & credit_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            imem_address     <= RESET_PC;
            imem_read_enable <= 1'b0;
            pipe_valid       <= '0;
            for (int i = 0; i < IMEM_LATENCY; i++) pipe_pc[i] <= '0;
        end else begin
            state            <= next_state;
            imem_read_enable <= issue;
            if (redirect_valid) begin
                pc <= redirect_target;
            end else if (issue) begin
                imem_address <= pc;
                pc           <= pc + 32'd1;
            end
            pipe_valid[0] <= imem_read_enable & ~redirect_valid;
            pipe_pc[0]    <= imem_address;
            for (int i = 1; i < IMEM_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1] & ~redirect_valid;
                pipe_pc[i]    <= pipe_pc[i-1];
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (q_count),
        .head      (q_head)
    );

    assign instr_valid = (q_count != '0);
    assign instr_data  = q_head.instr;
    assign instr_pc    = q_head.pc;
    assign fetch_busy  = (q_count != '0) | (|pipe_valid);

`ifdef FETCH_STALL_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if ((next_state == RUN) && !redirect_valid && !credit_ok && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
